// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: access size codes, memory-stage FSM states,
// bus widths and the load/store request legality check.
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // True when a load/store cannot be issued: conflicting strobes, illegal size or misalignment.
    function automatic logic access_err(
        input logic       rd,
        input logic       wr,
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        return (rd && wr)
            || (size == 2'd3)
            || ((size == SIZE_H) && addr_lo[0])
            || ((size == SIZE_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: byte enables and store replication toward the bus,
// lane select plus sign/zero extension for data returning from the bus.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [BE_W-1:0]   be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        be_o    = '0;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            SIZE_B: begin
                be_o    = BE_W'(4'b0001 << addr_lo_i);
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = unsigned_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            SIZE_W: begin
                be_o    = '1;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            default: begin
                be_o    = '0;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer: issues one request/ack bus transaction per
// load/store, stalls the pipeline until it completes, and returns extended load data.
module mem_access_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [1:0]          mem_size,
    input  logic                mem_unsigned,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [BE_W-1:0]     bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic [DATA_W-1:0]   load_data,
    output logic                done,
    output logic                stall,
    output logic                req_err,
    output logic                bus_err
);

    mem_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                bus_req_q;
    logic                bus_we_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [BE_W-1:0]     bus_be_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic [DATA_W-1:0]   load_data_q;
    logic                done_q;
    logic                bus_err_q;
    logic [1:0]          ld_size_q;
    logic                ld_unsigned_q;
    logic [1:0]          ld_lo_q;

    logic                access_c;
    logic                err_c;
    logic                issue_c;
    logic [BE_W-1:0]     st_be_c;
    logic [DATA_W-1:0]   st_wdata_c;
    logic [DATA_W-1:0]   ld_ext_c;
    logic [DATA_W-1:0]   unused_st_rdata_c;
    logic [BE_W-1:0]     unused_ld_be_c;
    logic [DATA_W-1:0]   unused_ld_wdata_c;

    assign access_c = mem_read | mem_write;
    assign err_c    = access_err(mem_read, mem_write, mem_size, addr[1:0]);
    assign issue_c  = (state_q == ST_IDLE) && access_c && !err_c;

    // Store path works on the live request so the bus fields can be latched at issue.
    mem_lane_align u_store_align (
        .size_i     (mem_size),
        .unsigned_i (mem_unsigned),
        .addr_lo_i  (addr[1:0]),
        .wdata_i    (wdata),
        .rdata_i    ('0),
        .be_o       (st_be_c),
        .wdata_o    (st_wdata_c),
        .rdata_o    (unused_st_rdata_c)
    );

    // Load path uses the shape latched at issue; the pipeline inputs may move on in DONE.
    mem_lane_align u_load_align (
        .size_i     (ld_size_q),
        .unsigned_i (ld_unsigned_q),
        .addr_lo_i  (ld_lo_q),
        .wdata_i    ('0),
        .rdata_i    (bus_rdata),
        .be_o       (unused_ld_be_c),
        .wdata_o    (unused_ld_wdata_c),
        .rdata_o    (ld_ext_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= '0;
            bus_wdata_q   <= '0;
            load_data_q   <= '0;
            done_q        <= 1'b0;
            bus_err_q     <= 1'b0;
            ld_size_q     <= SIZE_B;
            ld_unsigned_q <= 1'b0;
            ld_lo_q       <= 2'b00;
        end else begin
            done_q    <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue_c) begin
                        state_q       <= ST_REQ;
                        cnt_q         <= '0;
                        bus_req_q     <= 1'b1;
                        bus_we_q      <= mem_write;
                        bus_addr_q    <= {addr[ADDR_W-1:2], 2'b00};
                        bus_be_q      <= st_be_c;
                        bus_wdata_q   <= st_wdata_c;
                        ld_size_q     <= mem_size;
                        ld_unsigned_q <= mem_unsigned;
                        ld_lo_q       <= addr[1:0];
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        state_q     <= ST_DONE;
                        bus_req_q   <= 1'b0;
                        done_q      <= 1'b1;
                        load_data_q <= bus_we_q ? '0 : ld_ext_c;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q     <= ST_DONE;
                        bus_req_q   <= 1'b0;
                        done_q      <= 1'b1;
                        bus_err_q   <= 1'b1;
                        load_data_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // Requests still visible here belong to the access that just finished.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign load_data = load_data_q;
    assign done      = done_q;
    assign bus_err   = bus_err_q;

    assign req_err = access_c && err_c;
    assign stall   = !rst && (issue_c || (state_q == ST_REQ));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: store, loads, alignment errors, timeout,
// reset mid-transaction and back-to-back word loads.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [31:0] load_data;
    logic        done;
    logic        stall;
    logic        req_err;
    logic        bus_err;

    int checks = 0;
    int passed = 0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .load_data    (load_data),
        .done         (done),
        .stall        (stall),
        .req_err      (req_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_size     = 2'd0;
        mem_unsigned = 1'b0;
        addr         = '0;
        wdata        = '0;
        bus_ack      = 1'b0;
        bus_rdata    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        next_cyc();
        next_cyc();
        sample();
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        next_cyc();
        rst = 1'b0;

        // sw 0x100, ack three cycles after issue
        next_cyc();
        mem_write = 1'b1; mem_size = 2'd2; addr = 32'h100; wdata = 32'hDEADBEEF;
        sample();
        chk("sw_n_stall", 32'(stall), 32'd1);
        chk("sw_n_req", 32'(bus_req), 32'd0);
        chk("sw_n_req_err", 32'(req_err), 32'd0);
        next_cyc();
        sample();
        chk("sw_req", 32'(bus_req), 32'd1);
        chk("sw_we", 32'(bus_we), 32'd1);
        chk("sw_addr", bus_addr, 32'h100);
        chk("sw_be", 32'(bus_be), 32'hF);
        chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
        chk("sw_n1_stall", 32'(stall), 32'd1);
        next_cyc();
        sample();
        chk("sw_n2_stall", 32'(stall), 32'd1);
        chk("sw_n2_done", 32'(done), 32'd0);
        next_cyc();
        bus_ack = 1'b1;
        sample();
        chk("sw_n3_stall", 32'(stall), 32'd1);
        chk("sw_n3_req", 32'(bus_req), 32'd1);
        next_cyc();
        bus_ack = 1'b0;
        sample();
        chk("sw_done", 32'(done), 32'd1);
        chk("sw_done_stall", 32'(stall), 32'd0);
        chk("sw_done_req", 32'(bus_req), 32'd0);
        chk("sw_load_data", load_data, 32'd0);
        chk("sw_bus_err", 32'(bus_err), 32'd0);
        next_cyc();
        clear_inputs();
        sample();
        chk("sw_post_done", 32'(done), 32'd0);
        chk("sw_post_req", 32'(bus_req), 32'd0);

        // sh 0x002, immediate ack
        next_cyc();
        mem_write = 1'b1; mem_size = 2'd1; addr = 32'h002; wdata = 32'h0000ABCD;
        sample();
        chk("sh_stall", 32'(stall), 32'd1);
        next_cyc();
        bus_ack = 1'b1;
        sample();
        chk("sh_be", 32'(bus_be), 32'hC);
        chk("sh_wdata", bus_wdata, 32'hABCDABCD);
        chk("sh_addr", bus_addr, 32'h0);
        next_cyc();
        bus_ack = 1'b0;
        sample();
        chk("sh_done", 32'(done), 32'd1);
        next_cyc();
        clear_inputs();

        // lh 0x001 is misaligned: rejected, never issued
        next_cyc();
        mem_read = 1'b1; mem_size = 2'd1; addr = 32'h001;
        sample();
        chk("lh_err_req_err", 32'(req_err), 32'd1);
        chk("lh_err_stall", 32'(stall), 32'd0);
        next_cyc();
        sample();
        chk("lh_err_bus_req", 32'(bus_req), 32'd0);
        chk("lh_err_stall2", 32'(stall), 32'd0);
        next_cyc();
        mem_size = 2'd3; addr = 32'h0;
        sample();
        chk("size3_req_err", 32'(req_err), 32'd1);
        chk("size3_bus_req", 32'(bus_req), 32'd0);
        next_cyc();
        mem_write = 1'b1; mem_size = 2'd2;
        sample();
        chk("rdwr_req_err", 32'(req_err), 32'd1);
        chk("rdwr_stall", 32'(stall), 32'd0);
        next_cyc();
        clear_inputs();
        sample();
        chk("err_never_issued", 32'(bus_req), 32'd0);
        chk("err_no_done", 32'(done), 32'd0);
        chk("idle_req_err", 32'(req_err), 32'd0);

        // lb 0x203 then lbu 0x203, immediate ack with 0x80112233
        for (int u = 0; u < 2; u++) begin
            next_cyc();
            mem_read = 1'b1; mem_size = 2'd0; mem_unsigned = 1'(u); addr = 32'h203;
            sample();
            chk("lb_stall", 32'(stall), 32'd1);
            next_cyc();
            bus_ack = 1'b1; bus_rdata = 32'h80112233;
            sample();
            chk("lb_req", 32'(bus_req), 32'd1);
            chk("lb_we", 32'(bus_we), 32'd0);
            chk("lb_be", 32'(bus_be), 32'h8);
            chk("lb_addr", bus_addr, 32'h200);
            next_cyc();
            bus_ack = 1'b0; bus_rdata = 32'h0;
            sample();
            chk("lb_done", 32'(done), 32'd1);
            chk("lb_load_data", load_data, (u == 0) ? 32'hFFFFFF80 : 32'h00000080);
            next_cyc();
            clear_inputs();
        end

        // lw 0x40 with no ack: TIMEOUT=4 cycles of bus_req, then error completion
        next_cyc();
        mem_read = 1'b1; mem_size = 2'd2; addr = 32'h40;
        sample();
        chk("to_stall", 32'(stall), 32'd1);
        for (int k = 0; k < 4; k++) begin
            next_cyc();
            sample();
            chk("to_req_high", 32'(bus_req), 32'd1);
            chk("to_no_done", 32'(done), 32'd0);
        end
        next_cyc();
        sample();
        chk("to_req_low", 32'(bus_req), 32'd0);
        chk("to_done", 32'(done), 32'd1);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_load_data", load_data, 32'd0);
        next_cyc();
        clear_inputs();
        sample();
        chk("to_err_clears", 32'(bus_err), 32'd0);

        // reset during the second REQ cycle abandons the access
        next_cyc();
        mem_read = 1'b1; mem_size = 2'd2; addr = 32'h80;
        next_cyc();
        sample();
        chk("rstreq_req1", 32'(bus_req), 32'd1);
        next_cyc();
        rst = 1'b1;
        sample();
        chk("rstreq_req2", 32'(bus_req), 32'd1);
        next_cyc();
        rst = 1'b0;
        clear_inputs();
        sample();
        chk("rstreq_req_dropped", 32'(bus_req), 32'd0);
        chk("rstreq_stall", 32'(stall), 32'd0);
        next_cyc();
        bus_ack = 1'b1;
        sample();
        chk("rstreq_ack_ignored_req", 32'(bus_req), 32'd0);
        next_cyc();
        bus_ack = 1'b0;
        sample();
        chk("rstreq_no_done", 32'(done), 32'd0);

        // two lw back to back, ack one cycle after each issue
        next_cyc();
        mem_read = 1'b1; mem_size = 2'd2; addr = 32'h10;
        sample();
        chk("b2b_first_stall", 32'(stall), 32'd1);
        next_cyc();
        bus_ack = 1'b1; bus_rdata = 32'h11223344;
        sample();
        chk("b2b_first_req", 32'(bus_req), 32'd1);
        chk("b2b_first_addr", bus_addr, 32'h10);
        next_cyc();
        bus_ack = 1'b0;
        sample();
        chk("b2b_first_done", 32'(done), 32'd1);
        chk("b2b_first_data", load_data, 32'h11223344);
        chk("b2b_done_req", 32'(bus_req), 32'd0);
        next_cyc();
        addr = 32'h14;
        sample();
        chk("b2b_no_dup_issue", 32'(bus_req), 32'd0);
        chk("b2b_second_stall", 32'(stall), 32'd1);
        next_cyc();
        bus_ack = 1'b1; bus_rdata = 32'h55667788;
        sample();
        chk("b2b_second_req", 32'(bus_req), 32'd1);
        chk("b2b_second_addr", bus_addr, 32'h14);
        next_cyc();
        bus_ack = 1'b0;
        sample();
        chk("b2b_second_done", 32'(done), 32'd1);
        chk("b2b_second_data", load_data, 32'h55667788);
        next_cyc();
        clear_inputs();
        sample();
        chk("b2b_idle", 32'(bus_req), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
